mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the instruction-fetch stage and the load/store (MEM) stage of the 4-stage pipeline.
- Arbitrates between the two requesters, then sequences one fixed-latency memory access at a time.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Generates per-stage stall signals for the pipeline.
- Data accesses have priority; a starvation limit guarantees forward progress for fetch.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
LATENCY, 2, memory access cycles per transaction (legal range >= 1)
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (legal range >= 1)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
FetchReq  in  1  fetch request; held until FetchAck
FetchAddr  in  ADDR_WIDTH  fetch address; stable while FetchReq is high
FetchData  out  DATA_WIDTH  fetched instruction; valid when FetchAck is high, held otherwise
FetchAck  out  1  one-cycle completion pulse to fetch
FetchStall  out  1  fetch stage must stall
DataRE  in  1  load request (MemoryRE from decode path)
DataWE  in  1  store request (MemoryWE from decode path)
DataAddr  in  ADDR_WIDTH  load/store address
DataWrData  in  DATA_WIDTH  store data
DataRdData  out  DATA_WIDTH  load result; valid when DataAck is high, held otherwise
DataAck  out  1  one-cycle completion pulse to MEM stage
DataStall  out  1  MEM stage must stall
MemAddr  out  ADDR_WIDTH  memory address
MemWrData  out  DATA_WIDTH  memory write data
MemRE  out  1  memory read strobe
MemWE  out  1  memory write strobe
MemRdData  in  DATA_WIDTH  memory read data; valid in the last ACCESS cycle
ErrorFlag  out  1  sticky flag: DataRE and DataWE asserted together

Behaviour:
- Reset values: all outputs are 0; state is IDLE; starvation counter is 0; FetchData and DataRdData are 0.
- States are IDLE, ACCESS and DONE.
- IDLE, arbitration on the clock edge:
  - Data pending (DataRE|DataWE) with fetch not pending: grant data.
  - Fetch pending with data not pending: grant fetch.
  - Both pending: grant data, unless the starvation counter equals STARVE_LIMIT, in which case grant fetch.
  - On any grant: latch the address, write data, op (read/write) and grant owner; load the cycle counter with LATENCY-1; go to ACCESS.
  - Neither pending: stay in IDLE.
- Starvation counter:
  - Increments on a data grant while FetchReq is high.
  - Clears on a fetch grant, or on a data grant while FetchReq is low.
  - Saturates at STARVE_LIMIT.
- ACCESS:
  - MemAddr, MemWrData, MemRE and MemWE are driven from the latched registers and are stable for all LATENCY cycles.
  - Counter decrements each cycle.
  - When the counter is 0: capture MemRdData into the owner's read-data register (reads only); go to DONE.
- DONE, one cycle:
  - Mem strobes are 0.
  - Owner's Ack is 1 for exactly this cycle.
  - No arbitration this cycle.
  - Next state is IDLE.
- Outside ACCESS: MemRE, MemWE, MemAddr and MemWrData are all 0.
- Timing: a request sampled in IDLE at cycle T gives ACCESS in T+1..T+LATENCY and Ack in T+LATENCY+1. Throughput is one access per LATENCY+2 cycles.
- Requester contract: deassert, or present a new request, on the cycle after Ack. The DONE cycle guarantees a served request is never counted twice.
- Stall outputs (combinational):
  - FetchStall = FetchReq & ~FetchAck.
  - DataStall = (DataRE|DataWE) & ~DataAck.
- DataRE and DataWE high together: treated as a write; ErrorFlag is set and stays set until Reset.
- Requester inputs changing during ACCESS are ignored; the latched values are used.
- Reset in any state: the next cycle is IDLE with all outputs 0. The in-flight access is abandoned with no Ack, and MemWE drops immediately.
- Read-data registers hold their value until the next completion for the same port.

Test Plan:
- LATENCY=2; FetchReq=1, FetchAddr=0x40 at T; MemRdData=0x20080005 in T+2 -> MemRE=1, MemAddr=0x40 in T+1..T+2; FetchAck=1 and FetchData=0x20080005 at T+3; FetchStall=1 in T..T+2.
- FetchReq and DataWE both high at T, DataAddr=0x100, DataWrData=0xDEADBEEF -> data granted first (MemWE=1 in T+1..T+2, DataAck at T+3); fetch granted at T+4 with FetchAck at T+7.
- STARVE_LIMIT=2; FetchReq held high; DataRE re-asserted after every DataAck -> two data acks, then one fetch ack, then the counter has cleared.
- DataRE=DataWE=1, DataAddr=0x8 -> write performed (MemWE=1, MemRE=0); ErrorFlag=1 and still 1 after ten further idle cycles.
- Reset pulsed in the second ACCESS cycle of a store -> MemWE=0 the next cycle; no DataAck; state IDLE; ErrorFlag=0.
- LATENCY=1 back-to-back fetches at 0x0 and 0x4 -> FetchAck exactly every 3 cycles; FetchData matches MemRdData captured in each access cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between instruction fetch and the load/store
// stage. Data accesses win arbitration unless fetch has been passed over
// STARVE_LIMIT consecutive times. One access is in flight at a time: IDLE
// (arbitrate) -> ACCESS (LATENCY cycles, strobes held) -> DONE (one-cycle ack).
//
// Ports:
//   i_clock, i_reset                   clock, synchronous active-high reset
//   i_fetch_req/i_fetch_addr           fetch request and address
//   o_fetch_data/o_fetch_ack           fetched word and completion pulse
//   o_fetch_stall                      fetch stage stall
//   i_data_re/i_data_we                load / store request
//   i_data_addr/i_data_wr_data         load/store address and store data
//   o_data_rd_data/o_data_ack          load result and completion pulse
//   o_data_stall                       MEM stage stall
//   o_mem_addr/o_mem_wr_data           memory address and write data
//   o_mem_re/o_mem_we                  memory strobes (only during ACCESS)
//   i_mem_rd_data                      memory read data, valid in last ACCESS
//   o_error_flag                       sticky: load and store requested at once
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
    output logic [DATA_WIDTH-1:0] o_fetch_data,
    output logic                  o_fetch_ack,
    output logic                  o_fetch_stall,
    input  logic                  i_data_re,
    input  logic                  i_data_we,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [DATA_WIDTH-1:0] i_data_wr_data,
    output logic [DATA_WIDTH-1:0] o_data_rd_data,
    output logic                  o_data_ack,
    output logic                  o_data_stall,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic                  o_error_flag
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [SW-1:0]         r_starve;
    logic                  r_owner_data;   // 1: access belongs to the MEM stage
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic                  r_mem_re;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_fetch_data;
    logic [DATA_WIDTH-1:0] r_data_rd_data;
    logic                  r_fetch_ack;
    logic                  r_data_ack;
    logic                  r_error;

    logic w_data_pend;
    logic w_starved;
    logic w_grant_fetch;
    logic w_grant_data;

    assign w_data_pend   = i_data_re | i_data_we;
    assign w_starved     = (r_starve == STARVE_MAX);
    // Fetch wins only when data is idle or fetch has waited long enough.
    assign w_grant_fetch = i_fetch_req & (~w_data_pend | w_starved);
    assign w_grant_data  = w_data_pend & ~w_grant_fetch;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_starve       <= '0;
            r_owner_data   <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wr_data  <= '0;
            r_mem_re       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_fetch_data   <= '0;
            r_data_rd_data <= '0;
            r_fetch_ack    <= 1'b0;
            r_data_ack     <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, and the acks default low here so
            // they are single-cycle pulses without an explicit clear path.
            r_fetch_ack <= 1'b0;
            r_data_ack  <= 1'b0;
            if (i_data_re && i_data_we) begin
                r_error <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_fetch || w_grant_data) begin
                        r_state      <= S_ACCESS;
                        r_cnt        <= CNT_LOAD;
                        r_owner_data <= w_grant_data;
                        if (w_grant_data) begin
                            // Simultaneous load+store is performed as a store.
                            r_mem_addr    <= i_data_addr;
                            r_mem_wr_data <= i_data_wr_data;
                            r_mem_we      <= i_data_we;
                            r_mem_re      <= ~i_data_we;
                        end else begin
                            r_mem_addr    <= i_fetch_addr;
                            r_mem_wr_data <= '0;
                            r_mem_we      <= 1'b0;
                            r_mem_re      <= 1'b1;
                        end
                        // Count data grants that made a waiting fetch wait longer.
                        if (w_grant_data && i_fetch_req) begin
                            if (!w_starved) begin
                                r_starve <= r_starve + SW'(1);
                            end
                        end else begin
                            r_starve <= '0;
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (r_mem_re) begin
                            if (r_owner_data) begin
                                r_data_rd_data <= i_mem_rd_data;
                            end else begin
                                r_fetch_data <= i_mem_rd_data;
                            end
                        end
                        r_data_ack    <= r_owner_data;
                        r_fetch_ack   <= ~r_owner_data;
                        r_mem_addr    <= '0;
                        r_mem_wr_data <= '0;
                        r_mem_re      <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                S_DONE: begin
                    // Requester sees its ack now; arbitration resumes next cycle.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_fetch_data   = r_fetch_data;
    assign o_fetch_ack    = r_fetch_ack;
    assign o_fetch_stall  = i_fetch_req & ~r_fetch_ack;
    assign o_data_rd_data = r_data_rd_data;
    assign o_data_ack     = r_data_ack;
    assign o_data_stall   = w_data_pend & ~r_data_ack;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wr_data  = r_mem_wr_data;
    assign o_mem_re       = r_mem_re;
    assign o_mem_we       = r_mem_we;
    assign o_error_flag   = r_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_data;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference memory contents: arbitrary but address-dependent, 0x40 -> 0x20080005.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return 32'h20080005 ^ ((a ^ 32'h40) * 32'h9E3779B1);
    endfunction

    // ---------------- DUT A: LATENCY=2, STARVE_LIMIT=2 ----------------
    logic        fetch_req = 0, data_re = 0, data_we = 0;
    logic [31:0] fetch_addr = 0, data_addr = 0, data_wr_data = 0;
    logic [31:0] fetch_data, data_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic        fetch_ack, fetch_stall, data_ack, data_stall, mem_re, mem_we, error_flag;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(2), .STARVE_LIMIT(2)) dut_a (
        .i_clock(clk), .i_reset(rst),
        .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_data(fetch_data), .o_fetch_ack(fetch_ack), .o_fetch_stall(fetch_stall),
        .i_data_re(data_re), .i_data_we(data_we), .i_data_addr(data_addr),
        .i_data_wr_data(data_wr_data), .o_data_rd_data(data_rd_data),
        .o_data_ack(data_ack), .o_data_stall(data_stall),
        .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data), .o_mem_re(mem_re), .o_mem_we(mem_we),
        .i_mem_rd_data(mem_rd_data), .o_error_flag(error_flag)
    );

    // Memory A returns valid data only in the second (last) strobe cycle.
    int acc_a = 0;
    always @(posedge clk) acc_a <= (mem_re || mem_we) ? acc_a + 1 : 0;
    assign mem_rd_data = (mem_re && acc_a == 1) ? mem_model(mem_addr) : 32'hBADC0DE0;

    txn_t sb[$];
    txn_t mon_t;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re || mem_we) begin
                check("access_has_txn", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("mem_addr", mem_addr, sb[0].addr);
                    check("mem_we", mem_we, sb[0].is_write);
                    check("mem_re", mem_re, !sb[0].is_write);
                    if (sb[0].is_write) check("mem_wr_data", mem_wr_data, sb[0].wdata);
                end
            end
            if (fetch_ack || data_ack) begin
                check("ack_has_txn", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_t = sb.pop_front();
                    check("ack_owner_data", data_ack, mon_t.is_data);
                    check("ack_owner_fetch", fetch_ack, !mon_t.is_data);
                    if (!mon_t.is_write) begin
                        if (mon_t.is_data) check("data_rd_data", data_rd_data, mon_t.rdata);
                        else               check("fetch_data", fetch_data, mon_t.rdata);
                    end
                end
            end
        end
    end

    // ---------------- DUT B: LATENCY=1, STARVE_LIMIT=4 ----------------
    logic        b_fetch_req = 0;
    logic [31:0] b_fetch_addr = 0;
    logic [31:0] b_fetch_data, b_data_rd_data, b_mem_addr, b_mem_wr_data, b_mem_rd_data;
    logic        b_fetch_ack, b_fetch_stall, b_data_ack, b_data_stall, b_mem_re, b_mem_we, b_error;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1), .STARVE_LIMIT(4)) dut_b (
        .i_clock(clk), .i_reset(rst),
        .i_fetch_req(b_fetch_req), .i_fetch_addr(b_fetch_addr),
        .o_fetch_data(b_fetch_data), .o_fetch_ack(b_fetch_ack), .o_fetch_stall(b_fetch_stall),
        .i_data_re(1'b0), .i_data_we(1'b0), .i_data_addr(32'h0),
        .i_data_wr_data(32'h0), .o_data_rd_data(b_data_rd_data),
        .o_data_ack(b_data_ack), .o_data_stall(b_data_stall),
        .o_mem_addr(b_mem_addr), .o_mem_wr_data(b_mem_wr_data), .o_mem_re(b_mem_re), .o_mem_we(b_mem_we),
        .i_mem_rd_data(b_mem_rd_data), .o_error_flag(b_error)
    );

    assign b_mem_rd_data = b_mem_re ? mem_model(b_mem_addr) : 32'hBADC0DE1;

    logic [31:0] qb[$];
    logic [31:0] mon_b;

    always @(negedge clk) begin
        if (!rst && b_fetch_ack) begin
            check("b_ack_has_txn", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                mon_b = qb.pop_front();
                check("b_fetch_data", b_fetch_data, mon_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic txn_t mk(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.is_data = d; t.is_write = w; t.addr = a; t.wdata = wd; t.rdata = mem_model(a);
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int last;
        bit was_fetch;

        // ---------------- reset state ----------------
        repeat (3) step();
        settle();
        check("rst_fetch_ack", fetch_ack, 0);
        check("rst_data_ack", data_ack, 0);
        check("rst_mem_strobes", {mem_re, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
        check("rst_fetch_data", fetch_data, 0);
        check("rst_data_rd_data", data_rd_data, 0);
        check("rst_error", error_flag, 0);
        check("rst_stalls", {fetch_stall, data_stall}, 0);
        step();
        rst = 0;

        // ---------------- single fetch, LATENCY=2 ----------------
        step();
        fetch_req = 1; fetch_addr = 32'h40;
        sb.push_back(mk(0, 0, 32'h40, 0));
        settle();
        check("t1_stall_T", fetch_stall, 1);
        check("t1_no_strobe_T", mem_re, 0);
        for (int k = 1; k <= 2; k++) begin
            step(); settle();
            check("t1_mem_re", mem_re, 1);
            check("t1_mem_addr", mem_addr, 32'h40);
            check("t1_stall", fetch_stall, 1);
            check("t1_no_ack", fetch_ack, 0);
        end
        step(); settle();
        check("t1_ack", fetch_ack, 1);
        check("t1_data", fetch_data, 32'h20080005);
        check("t1_stall_ack", fetch_stall, 0);
        check("t1_strobe_done", mem_re, 0);
        step();
        fetch_req = 0;
        settle();
        check("t1_ack_pulse", fetch_ack, 0);
        check("t1_data_held", fetch_data, 32'h20080005);

        // ---------------- fetch vs store: data first ----------------
        step();
        fetch_req = 1; fetch_addr = 32'h80;
        data_we = 1; data_addr = 32'h100; data_wr_data = 32'hDEADBEEF;
        sb.push_back(mk(1, 1, 32'h100, 32'hDEADBEEF));
        sb.push_back(mk(0, 0, 32'h80, 0));
        settle();
        check("t2_stalls_T", {fetch_stall, data_stall}, 2'b11);
        for (int k = 1; k <= 2; k++) begin
            step(); settle();
            check("t2_mem_we", {mem_we, mem_re}, 2'b10);
        end
        step(); settle();
        check("t2_data_ack", {data_ack, fetch_ack}, 2'b10);
        check("t2_stalls_ack", {fetch_stall, data_stall}, 2'b10);
        step();
        data_we = 0;
        settle();
        check("t2_idle_strobes", {mem_re, mem_we}, 0);
        for (int k = 5; k <= 6; k++) begin
            step(); settle();
            check("t2_fetch_re", {mem_re, mem_we}, 2'b10);
        end
        step(); settle();
        check("t2_fetch_ack_T7", {fetch_ack, data_ack}, 2'b10);
        step();
        fetch_req = 0;

        // ---------------- starvation limit 2 ----------------
        step();
        fetch_req = 1; fetch_addr = 32'h200;
        data_re = 1; data_addr = 32'h300;
        sb.push_back(mk(1, 0, 32'h300, 0));
        sb.push_back(mk(1, 0, 32'h300, 0));
        sb.push_back(mk(0, 0, 32'h200, 0));
        sb.push_back(mk(1, 0, 32'h300, 0));
        sb.push_back(mk(1, 0, 32'h300, 0));
        sb.push_back(mk(0, 0, 32'h204, 0));
        acks = 0; last = -1;
        for (int c = 0; c < 60 && acks < 6; c++) begin
            settle();
            was_fetch = fetch_ack;
            if (fetch_ack || data_ack) begin
                acks++;
                if (last >= 0) check("t3_ack_spacing", cyc - last, 4);
                last = cyc;
            end
            step();
            if (was_fetch) fetch_addr = 32'h204;
        end
        check("t3_ack_count", acks, 6);
        fetch_req = 0; data_re = 0;

        // ---------------- load+store together ----------------
        step();
        data_re = 1; data_we = 1; data_addr = 32'h8; data_wr_data = 32'h12345678;
        sb.push_back(mk(1, 1, 32'h8, 32'h12345678));
        step(); settle();
        check("t4_write_strobes", {mem_we, mem_re}, 2'b10);
        check("t4_error", error_flag, 1);
        step(); step(); settle();
        check("t4_ack", data_ack, 1);
        step();
        data_re = 0; data_we = 0;
        repeat (10) step();
        settle();
        check("t4_error_sticky", error_flag, 1);

        // ---------------- reset during store ----------------
        step();
        data_we = 1; data_addr = 32'h10; data_wr_data = 32'hCAFEF00D;
        sb.push_back(mk(1, 1, 32'h10, 32'hCAFEF00D));
        step(); settle();
        check("t5_access1_we", mem_we, 1);
        step();
        rst = 1;
        settle();
        check("t5_access2_we", mem_we, 1);
        step();
        rst = 0; data_we = 0;
        sb.delete();
        settle();
        check("t5_we_dropped", {mem_we, mem_re}, 0);
        check("t5_mem_addr", mem_addr, 0);
        check("t5_no_ack", data_ack, 0);
        check("t5_error_cleared", error_flag, 0);
        step(); settle();
        check("t5_no_ack_later", {data_ack, mem_we}, 0);
        // IDLE check: a fresh fetch completes on the normal schedule.
        step();
        fetch_req = 1; fetch_addr = 32'h44;
        sb.push_back(mk(0, 0, 32'h44, 0));
        repeat (3) step();
        settle();
        check("t5_idle_fetch_ack", fetch_ack, 1);
        step();
        fetch_req = 0;

        // ---------------- LATENCY=1 back-to-back fetches ----------------
        step();
        b_fetch_req = 1; b_fetch_addr = 32'h0;
        qb.push_back(mem_model(32'h0));
        qb.push_back(mem_model(32'h4));
        acks = 0; last = -1;
        for (int c = 0; c < 20 && acks < 2; c++) begin
            settle();
            was_fetch = b_fetch_ack;
            if (b_fetch_ack) begin
                acks++;
                if (last >= 0) check("t6_ack_spacing", cyc - last, 3);
                last = cyc;
            end
            step();
            if (was_fetch) b_fetch_addr = 32'h4;
        end
        check("t6_ack_count", acks, 2);
        b_fetch_req = 0;

        repeat (3) step();
        check("sb_empty", sb.size(), 0);
        check("qb_empty", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
